serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits (legal range 2..32).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to add the operands presented this cycle.
REQ-005 A  input  WIDTH  operand A, sampled only on an accepted start.
REQ-006 B  input  WIDTH  operand B, sampled only on an accepted start.
REQ-007 Cin  input  1  carry-in, sampled only on an accepted start.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse; S/Cout valid from this cycle.
REQ-010 S  output  WIDTH  registered sum.
REQ-011 Cout  output  1  registered carry-out.

Function
REQ-012 Block SHALL compute {Cout,S} = A + B + Cin bit-serially, LSB first, one full-adder bit per clock, with a registered carry between bits.
REQ-013 FSM SHALL have states IDLE, RUN, DONE.
REQ-014 IDLE: start=1 accepted -> latch A, B, Cin into shift/carry registers, clear bit counter, go RUN; start=0 -> stay IDLE.
REQ-015 RUN: each cycle add the current LSBs of A and B plus the carry register, shift the sum bit into the result register MSB-side, shift A and B right, update carry, increment counter.
REQ-016 RUN SHALL last exactly WIDTH cycles; after the WIDTH-th bit go DONE.
REQ-017 DONE: S <= result register, Cout <= final carry, done=1 for this one cycle, then go IDLE.
REQ-018 Latency: start accepted on edge k -> done=1 in the cycle following edge k+WIDTH+1; back-to-back throughput is one addition per WIDTH+2 cycles.
REQ-019 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-020 start while busy=1 SHALL be ignored: no operand capture and no effect on the in-flight result.
REQ-021 start asserted in the DONE cycle SHALL be ignored; a new start is accepted only in IDLE.
REQ-022 S and Cout SHALL hold their last values between done pulses and change only in the DONE cycle.
REQ-023 Carry SHALL propagate fully; for example, all-ones + 1 SHALL yield S=0 and Cout=1.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, S=0, Cout=0, and clear the carry, counter and shift registers.
REQ-025 rst=1 during RUN or DONE SHALL abort the operation with no done pulse; the partial result SHALL be discarded.
REQ-026 rst SHALL take priority over start in the same cycle.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN defined SHALL add output port OVF (1 bit) giving signed overflow = carry into MSB XOR carry out of MSB, updated in the DONE cycle, reset to 0, and held like S.
REQ-028 Macro SERIAL_ADDER_OVF_EN undefined SHALL remove the OVF port and its logic, with all other behaviour identical.

Verification
REQ-029 WIDTH=8, A=0x0F, B=0x01, Cin=0, start pulse -> done after 10 cycles, S=0x10, Cout=0, busy high for 9 cycles.
REQ-030 A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1; A=0xFF, B=0xFF, Cin=1 -> S=0xFF, Cout=1.
REQ-031 Start A=0x12, B=0x34; in the RUN cycle 3 pulse start with A=0xFF, B=0xFF -> single done, S=0x46, Cout=0, no second done.
REQ-032 Start A=0xAA, B=0x55, assert rst in the RUN cycle 4 -> no done pulse, S=0, Cout=0, busy=0; a following start A=0x01, B=0x01 -> S=0x02.
REQ-033 With SERIAL_ADDER_OVF_EN: A=0x7F, B=0x01 -> S=0x80, OVF=1, Cout=0; A=0xFF, B=0x01 -> OVF=0, Cout=1.
REQ-034 Random sweep of 1000 operand triples, each result SHALL match the reference {Cout,S}=A+B+Cin.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder computing {Cout,S} = A + B + Cin, LSB first,
// one full-adder bit per clock with a registered carry between bits.
// A start is accepted only in IDLE. RUN then lasts exactly WIDTH cycles, followed
// by one DONE cycle. S/Cout/done are registered at the end of the DONE cycle, so
// done pulses in the cycle after DONE.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the OVF output, which
// reports signed overflow (carry into MSB XOR carry out of MSB).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  // The bit counter only needs to count 0..WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] s_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             done_reg;
  logic [CW-1:0]    cnt_reg;
  logic             last_bit;
  logic             sum_bit;
  logic             carry_next;

  // This cycle's full-adder bit: current LSBs plus the registered carry.
  assign sum_bit    = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
  assign carry_next = (a_sh_reg[0] & b_sh_reg[0]) |
                      (a_sh_reg[0] & carry_reg)   |
                      (b_sh_reg[0] & carry_reg);
  assign last_bit   = (cnt_reg == CW'(WIDTH - 1));

  // State register; reset takes priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. Starts are honoured only in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: busy covers both RUN and DONE.
  always_comb begin
    busy = 1'b0;
    if (state_reg != IDLE) busy = 1'b1;
  end

  // Datapath: operand capture, serial add/shift, and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      result_reg <= '0;
      s_reg      <= '0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      done_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg  <= A;
            b_sh_reg  <= B;
            carry_reg <= Cin;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
          result_reg <= {sum_bit, result_reg[WIDTH-1:1]};
          a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
          carry_reg  <= carry_next;
          cnt_reg    <= cnt_reg + 1'b1;
        end
        DONE: begin
          s_reg    <= result_reg;
          cout_reg <= carry_reg;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign S    = s_reg;
  assign Cout = cout_reg;
  assign done = done_reg;

`ifdef SERIAL_ADDER_OVF_EN
  logic c_msb_reg;
  logic ovf_reg;

  // Record the carry going into the MSB, then publish overflow alongside S.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_msb_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      if (state_reg == RUN && last_bit) c_msb_reg <= carry_reg;
      if (state_reg == DONE) ovf_reg <= c_msb_reg ^ carry_reg;
    end
  end

  assign OVF = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Cin   (cin),
    .busy  (busy),
    .done  (done),
    .S     (s),
    .Cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .OVF   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One addition started from the current negedge; returns at the done cycle.
  task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input string tag);
    logic [W:0] ref_sum;
    int n;
    int bc;
    ref_sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    start = 1'b1; a = x; b = y; cin = ci;
    @(negedge clk);
    start = 1'b0;
    n = 1; bc = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 10);
    check({tag, "_busy_cycles"}, bc, 9);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_S"}, s, ref_sum[W-1:0]);
    check({tag, "_Cout"}, cout, ref_sum[W]);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_OVF"}, ovf, (x[W-1] == y[W-1]) && (ref_sum[W-1] != x[W-1]));
`endif
    $display("add %s A=0x%02h B=0x%02h Cin=%0d -> S=0x%02h Cout=%0d cycles=%0d",
             tag, x, y, ci, s, cout, n);
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_S", s, 0);
    check("reset_Cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset_OVF", ovf, 0);
`endif
    // Reset wins over a simultaneous start.
    start = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    check("rst_over_start_busy", busy, 0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Basic vectors.
    do_add(8'h0F, 8'h01, 1'b0, "basic");
    @(negedge clk);
    check("done_one_cycle", done, 0);
    do_add(8'hFF, 8'h01, 1'b0, "carry_chain");
    do_add(8'hFF, 8'hFF, 1'b1, "all_ones_cin");
    do_add(8'h7F, 8'h01, 1'b0, "signed_ovf");
    do_add(8'h80, 8'h80, 1'b0, "neg_ovf");
    do_add(8'h00, 8'h00, 1'b1, "cin_only");

    // Start pulsed during RUN cycle 3 is ignored.
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk); start = 1'b0;
    n = 4;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("run_start_latency", n, 10);
    check("run_start_S", s, 8'h46);
    check("run_start_Cout", cout, 0);
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("run_start_no_second_done", pulses, 0);
    check("run_start_S_hold", s, 8'h46);

    // Start in the DONE cycle is ignored.
    start = 1'b1; a = 8'h03; b = 8'h04; cin = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    check("done_cycle_busy", busy, 1);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk); start = 1'b0;
    check("done_cycle_done", done, 1);
    check("done_cycle_S", s, 8'h07);
    @(negedge clk);
    check("done_cycle_start_ignored", busy, 0);
    repeat (3) @(negedge clk);
    check("hold_S", s, 8'h07);
    $display("done-cycle start ignored, S=0x%02h", s);

    // Reset during RUN cycle 4 aborts the operation.
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_S", s, 0);
    check("abort_Cout", cout, 0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 0);
    $display("abort during RUN: S=0x%02h busy=%0d", s, busy);
    do_add(8'h01, 8'h01, 1'b0, "after_abort");

    // Random back-to-back sweep (start issued in each done cycle).
    for (int i = 0; i < 1000; i++) begin
      do_add(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
